// File: rtl/ddr3_wr_pkg.sv
// Shared types and constants for the DDR3 write-side controller.
package ddr3_wr_pkg;

    localparam int unsigned DATA_W   = 128;
    localparam int unsigned ADR_STEP = 8;
    localparam int unsigned CNT_W    = 24;
    localparam int unsigned CSUM_W   = 32;
    localparam int unsigned MASK_W   = 16;
    localparam int unsigned CMD_W    = 3;

    localparam logic [CMD_W-1:0] APP_CMD_WR = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } wr_state_e;

    // XOR of the four 32-bit lanes of one FIFO word
    function automatic logic [CSUM_W-1:0] fold_word(input logic [DATA_W-1:0] d);
        return d[127:96] ^ d[95:64] ^ d[63:32] ^ d[31:0];
    endfunction

endpackage

// File: rtl/ddr3_wr_control_if.sv
// FWFT FIFO read side plus MIG app write interface.
interface ddr3_wr_control_if #(
    parameter int unsigned ADDR_W = 28
);
    import ddr3_wr_pkg::*;

    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_empty;
    logic              fifo_rd_en;

    logic              app_rdy;
    logic              app_wdf_rdy;
    logic              app_en;
    logic [CMD_W-1:0]  app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic [DATA_W-1:0] app_wdf_data;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic [MASK_W-1:0] app_wdf_mask;

    modport master (
        input  fifo_dout, fifo_empty, app_rdy, app_wdf_rdy,
        output fifo_rd_en, app_en, app_cmd, app_addr,
               app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask
    );

    modport slave (
        output fifo_dout, fifo_empty, app_rdy, app_wdf_rdy,
        input  fifo_rd_en, app_en, app_cmd, app_addr,
               app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask
    );

endinterface

// File: rtl/ddr3_wr_addr_cntr.sv
// Running DDR3 burst address with sticky wrap flag.
module ddr3_wr_addr_cntr
    import ddr3_wr_pkg::*;
#(
    parameter int unsigned ADDR_W = 28
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              wrap
);

    logic [ADDR_W:0] sum_c;

    assign sum_c = {1'b0, addr} + (ADDR_W+1)'(ADR_STEP);

    // Clear on init, advance one burst per committed word; carry out marks a wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr <= '0;
            wrap <= 1'b0;
        end else if (init) begin
            addr <= '0;
            wrap <= 1'b0;
        end else if (step) begin
            addr <= sum_c[ADDR_W-1:0];
            if (sum_c[ADDR_W]) begin
                wrap <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr3_wr_control.sv
// Drains the DDR3 write FIFO into the MIG app interface, one BL8 burst per word.
module ddr3_wr_control
    import ddr3_wr_pkg::*;
#(
    parameter int unsigned ADDR_W = 28
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                adr_init,
    input  logic                fill_done,
    ddr3_wr_control_if.master   bus,
    output logic                ddr3_wr_busy,
    output logic [CNT_W-1:0]    words_written,
    output logic [CSUM_W-1:0]   checksum,
    output logic                adr_wrap
);

    wr_state_e         state, state_nxt;

    logic              fd_latch, fd_latch_nxt;
    logic              hold_vld, hold_vld_nxt;
    logic              cmd_ok, cmd_ok_nxt;
    logic              dat_ok, dat_ok_nxt;
    logic              app_en_q, app_en_nxt;
    logic              wren_q, wren_nxt;
    logic [DATA_W-1:0] hold_q;

    logic              cmd_done_c;
    logic              dat_done_c;
    logic              commit_c;
    logic              word_free_c;
    logic              pop_c;
    logic              clr_fill_c;
    logic [ADDR_W-1:0] addr;

    // A word commits once both its command and its data have been accepted
    assign cmd_done_c  = cmd_ok | (app_en_q & bus.app_rdy);
    assign dat_done_c  = dat_ok | (wren_q & bus.app_wdf_rdy);
    assign commit_c    = (state == ST_ISSUE) & hold_vld & cmd_done_c & dat_done_c;
    assign word_free_c = ~hold_vld | commit_c;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (!bus.fifo_empty) begin
                    state_nxt = ST_ISSUE;
                end else if (fd_latch) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_ISSUE: begin
                if (word_free_c && bus.fifo_empty && fd_latch) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pop decision and next values of the handshake flags
    always_comb begin
        pop_c        = 1'b0;
        clr_fill_c   = 1'b0;
        app_en_nxt   = app_en_q & ~bus.app_rdy;
        wren_nxt     = wren_q & ~bus.app_wdf_rdy;
        cmd_ok_nxt   = cmd_done_c;
        dat_ok_nxt   = dat_done_c;
        hold_vld_nxt = hold_vld;
        fd_latch_nxt = fd_latch | fill_done;
        unique case (state)
            ST_IDLE: begin
                pop_c      = ~bus.fifo_empty;
                clr_fill_c = ~bus.fifo_empty | fd_latch;
            end
            ST_ISSUE: begin
                pop_c = word_free_c & ~bus.fifo_empty;
            end
            default: begin
                pop_c = 1'b0;
            end
        endcase
        if (commit_c) begin
            cmd_ok_nxt   = 1'b0;
            dat_ok_nxt   = 1'b0;
            hold_vld_nxt = 1'b0;
        end
        if (pop_c) begin
            app_en_nxt   = 1'b1;
            wren_nxt     = 1'b1;
            hold_vld_nxt = 1'b1;
        end
        if ((state_nxt == ST_DONE) && (state != ST_DONE)) begin
            fd_latch_nxt = 1'b0;
        end
    end

    // Handshake flags, hold register, per-fill statistics and busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fd_latch      <= 1'b0;
            hold_vld      <= 1'b0;
            cmd_ok        <= 1'b0;
            dat_ok        <= 1'b0;
            app_en_q      <= 1'b0;
            wren_q        <= 1'b0;
            hold_q        <= '0;
            words_written <= '0;
            checksum      <= '0;
            ddr3_wr_busy  <= 1'b0;
        end else begin
            fd_latch     <= fd_latch_nxt;
            hold_vld     <= hold_vld_nxt;
            cmd_ok       <= cmd_ok_nxt;
            dat_ok       <= dat_ok_nxt;
            app_en_q     <= app_en_nxt;
            wren_q       <= wren_nxt;
            ddr3_wr_busy <= (state_nxt != ST_IDLE) | fd_latch_nxt;
            if (pop_c) begin
                hold_q <= bus.fifo_dout;
            end
            if (clr_fill_c) begin
                words_written <= '0;
                checksum      <= '0;
            end else if (commit_c) begin
                if (words_written != {CNT_W{1'b1}}) begin
                    words_written <= words_written + CNT_W'(1);
                end
                checksum <= checksum ^ fold_word(hold_q);
            end
        end
    end

    ddr3_wr_addr_cntr #(
        .ADDR_W (ADDR_W)
    ) u_addr_cntr (
        .clk    (clk),
        .reset  (reset),
        .init   (adr_init & (state == ST_IDLE)),
        .step   (commit_c),
        .addr   (addr),
        .wrap   (adr_wrap)
    );

    assign bus.fifo_rd_en   = pop_c & ~reset;
    assign bus.app_en       = app_en_q;
    assign bus.app_cmd      = APP_CMD_WR;
    assign bus.app_addr     = addr;
    assign bus.app_wdf_data = hold_q;
    assign bus.app_wdf_wren = wren_q;
    assign bus.app_wdf_end  = wren_q;
    assign bus.app_wdf_mask = '0;

endmodule

// File: tb/tb_ddr3_wr_control.sv
// Directed bench for ddr3_wr_control with a small FWFT FIFO model and a MIG-side monitor.
module tb_ddr3_wr_control;
    import ddr3_wr_pkg::*;

    // Narrow address so the wrap case is reachable in a few words
    localparam int unsigned TB_ADDR_W = 6;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 adr_init;
    logic                 fill_done;
    logic                 ddr3_wr_busy;
    logic [CNT_W-1:0]     words_written;
    logic [CSUM_W-1:0]    checksum;
    logic                 adr_wrap;

    ddr3_wr_control_if #(.ADDR_W(TB_ADDR_W)) bus ();

    ddr3_wr_control #(
        .ADDR_W (TB_ADDR_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .adr_init      (adr_init),
        .fill_done     (fill_done),
        .bus           (bus),
        .ddr3_wr_busy  (ddr3_wr_busy),
        .words_written (words_written),
        .checksum      (checksum),
        .adr_wrap      (adr_wrap)
    );

    always #5 clk = ~clk;

    // FWFT FIFO model
    logic [DATA_W-1:0] fifo_mem [0:63];
    int unsigned       wr_ptr = 0;
    int unsigned       rd_ptr = 0;

    assign bus.fifo_empty = (wr_ptr == rd_ptr);
    assign bus.fifo_dout  = fifo_mem[rd_ptr[5:0]];

    always @(posedge clk) begin
        if (bus.fifo_rd_en && (wr_ptr != rd_ptr)) rd_ptr <= rd_ptr + 1;
    end

    // MIG-side monitor, sampled mid-cycle
    int                 cyc = 0, ncmd = 0, ndat = 0;
    int                 en_cnt = 0, wren_cnt = 0, busy_cnt = 0, fall_cyc = 0;
    logic               prev_busy = 1'b0;
    logic [TB_ADDR_W-1:0] cmd_addr [0:255];
    int                 cmd_cyc  [0:255];
    logic [DATA_W-1:0]  dat_log  [0:255];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.app_en) en_cnt = en_cnt + 1;
        if (bus.app_wdf_wren) wren_cnt = wren_cnt + 1;
        if (ddr3_wr_busy) busy_cnt = busy_cnt + 1;
        if (prev_busy && !ddr3_wr_busy) fall_cyc = cyc;
        prev_busy = ddr3_wr_busy;
        if (bus.app_en && bus.app_rdy && ncmd < 256) begin
            cmd_addr[ncmd] = bus.app_addr;
            cmd_cyc[ncmd]  = cyc;
            ncmd = ncmd + 1;
        end
        if (bus.app_wdf_wren && bus.app_wdf_rdy && ndat < 256) begin
            dat_log[ndat] = bus.app_wdf_data;
            ndat = ndat + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        fifo_mem[wr_ptr[5:0]] = w;
        wr_ptr++;
    endtask

    task automatic pulse_fill_done();
        fill_done = 1'b1;
        tick();
        fill_done = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        tick();
        tick();
        while (ddr3_wr_busy && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check_val("idle_timeout", 1, 0);
        tick();
    endtask

    localparam logic [127:0] W_A  = 128'h00000001_00000002_00000004_00000008;
    localparam logic [127:0] W_B  = 128'h10000000_20000000_40000000_80000000;
    localparam logic [127:0] W_C  = 128'h12345678_00000000_00000000_00000000;
    localparam logic [127:0] W_D  = 128'h00000000_00000000_00000000_000000FF;
    localparam logic [127:0] W_W1 = 128'h00000000_00000000_00000000_0000F00D;
    localparam logic [127:0] W_W2 = 128'hA5000000_00000000_00000000_00000000;
    localparam logic [127:0] W_E0 = 128'h00000000_00000000_00000000_00000001;
    localparam logic [127:0] W_E  = 128'h0BAD0BAD_00000000_00000000_00000000;
    localparam logic [127:0] W_F  = 128'hDEADBEEF_00000000_00000000_00000000;
    localparam logic [127:0] W_G1 = 128'hFFFF0000_0000FFFF_00000000_00000000;
    localparam logic [127:0] W_G2 = 128'h00000000_00000000_00000000_AAAAAAAA;
    localparam logic [127:0] W_G3 = 128'h00000000_00000000_12340000_00000000;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, d, e0, w0, bz;
        reset = 1'b1;
        adr_init = 1'b0;
        fill_done = 1'b0;
        bus.app_rdy = 1'b0;
        bus.app_wdf_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_app_en", bus.app_en, 0);
        check_val("rst_wren", bus.app_wdf_wren, 0);
        check_val("rst_addr", bus.app_addr, 0);
        check_val("rst_busy", ddr3_wr_busy, 0);
        check_val("rst_words", words_written, 0);
        check_val("rst_csum", checksum, 0);
        reset = 1'b0;
        tick();

        // Three back-to-back words with both ready signals high
        adr_init = 1'b1;
        tick();
        adr_init = 1'b0;
        check_val("t1_addr_init", bus.app_addr, 0);
        bus.app_rdy = 1'b1;
        bus.app_wdf_rdy = 1'b1;
        b = ncmd;
        d = ndat;
        push(W_A); push(W_B); push(W_C);
        fill_done = 1'b1;
        @(negedge clk);
        check_val("t1_pop", bus.fifo_rd_en, 1);
        check_val("t1_en_before", bus.app_en, 0);
        tick();
        fill_done = 1'b0;
        @(negedge clk);
        check_val("t1_en_after", bus.app_en, 1);
        check_val("t1_wdf_end", bus.app_wdf_end, 1);
        check_val("t1_cmd", bus.app_cmd, 0);
        check_val("t1_mask", bus.app_wdf_mask, 0);
        wait_idle();
        check_val("t1_ncmd", ncmd - b, 3);
        check_val("t1_addr0", cmd_addr[b], 0);
        check_val("t1_addr1", cmd_addr[b+1], 8);
        check_val("t1_addr2", cmd_addr[b+2], 16);
        check_val("t1_b2b_1", cmd_cyc[b+1] - cmd_cyc[b], 1);
        check_val("t1_b2b_2", cmd_cyc[b+2] - cmd_cyc[b+1], 1);
        check_val("t1_dat0", dat_log[d], W_A);
        check_val("t1_dat2", dat_log[d+2], W_C);
        check_val("t1_words", words_written, 3);
        check_val("t1_csum", checksum, 32'hE2345677);
        check_val("t1_busy_fall", fall_cyc - cmd_cyc[b+2], 2);

        // Command stalled four cycles, data accepted at once
        e0 = en_cnt; w0 = wren_cnt; b = ncmd; d = ndat;
        push(W_D);
        fill_done = 1'b1;
        bus.app_rdy = 1'b0;
        tick();
        fill_done = 1'b0;
        repeat (4) tick();
        bus.app_rdy = 1'b1;
        wait_idle();
        check_val("t2_en_cycles", en_cnt - e0, 5);
        check_val("t2_wren_cycles", wren_cnt - w0, 1);
        check_val("t2_ncmd", ncmd - b, 1);
        check_val("t2_cmd_addr", cmd_addr[b], 24);
        check_val("t2_dat", dat_log[d], W_D);
        check_val("t2_addr_after", bus.app_addr, 32);
        check_val("t2_words", words_written, 1);
        check_val("t2_csum", checksum, 32'h000000FF);

        // Zero-length fill
        bz = busy_cnt; b = ncmd;
        pulse_fill_done();
        repeat (6) tick();
        check_val("t3_busy_cycles", busy_cnt - bz, 2);
        check_val("t3_words", words_written, 0);
        check_val("t3_csum", checksum, 0);
        check_val("t3_ncmd", ncmd - b, 0);
        check_val("t3_addr", bus.app_addr, 32);

        // Address wrap past the top of the address space
        adr_init = 1'b1;
        tick();
        adr_init = 1'b0;
        check_val("t4_addr_init", bus.app_addr, 0);
        for (int k = 0; k < 7; k++) push({96'h0, 32'(k + 1)});
        pulse_fill_done();
        wait_idle();
        check_val("t4_preset_addr", bus.app_addr, 56);
        check_val("t4_preset_wrap", adr_wrap, 0);
        check_val("t4_preset_words", words_written, 7);
        b = ncmd;
        push(W_W1); push(W_W2);
        pulse_fill_done();
        wait_idle();
        check_val("t4_addr_a", cmd_addr[b], 56);
        check_val("t4_addr_b", cmd_addr[b+1], 0);
        check_val("t4_wrap", adr_wrap, 1);
        check_val("t4_addr_after", bus.app_addr, 8);
        check_val("t4_words", words_written, 2);
        check_val("t4_csum", checksum, 32'hA500F00D);
        adr_init = 1'b1;
        tick();
        adr_init = 1'b0;
        check_val("t4_clr_addr", bus.app_addr, 0);
        check_val("t4_clr_wrap", adr_wrap, 0);

        // Reset while a command is outstanding
        push(W_E0);
        pulse_fill_done();
        wait_idle();
        check_val("t5_pre_addr", bus.app_addr, 8);
        check_val("t5_pre_words", words_written, 1);
        bus.app_rdy = 1'b0;
        bus.app_wdf_rdy = 1'b0;
        push(W_E);
        tick();
        @(negedge clk);
        check_val("t5_inflight", bus.app_en, 1);
        #2;
        reset = 1'b1;
        #1;
        check_val("t5_rst_en", bus.app_en, 0);
        check_val("t5_rst_wren", bus.app_wdf_wren, 0);
        check_val("t5_rst_addr", bus.app_addr, 0);
        check_val("t5_rst_data", bus.app_wdf_data, 0);
        check_val("t5_rst_busy", ddr3_wr_busy, 0);
        check_val("t5_rst_words", words_written, 0);
        check_val("t5_rst_csum", checksum, 0);
        tick();
        tick();
        reset = 1'b0;
        bus.app_rdy = 1'b1;
        bus.app_wdf_rdy = 1'b1;
        b = ncmd; d = ndat;
        push(W_F);
        pulse_fill_done();
        wait_idle();
        check_val("t5_post_addr", cmd_addr[b], 0);
        check_val("t5_post_dat", dat_log[d], W_F);
        check_val("t5_post_words", words_written, 1);
        check_val("t5_post_csum", checksum, 32'hDEADBEEF);

        // FIFO runs dry mid-fill, then one more word
        b = ncmd;
        push(W_G1); push(W_G2);
        repeat (4) tick();
        e0 = en_cnt;
        repeat (10) tick();
        check_val("t6_gap_en", en_cnt - e0, 0);
        check_val("t6_gap_busy", ddr3_wr_busy, 1);
        push(W_G3);
        pulse_fill_done();
        wait_idle();
        check_val("t6_ncmd", ncmd - b, 3);
        check_val("t6_addr_last", cmd_addr[b+2], 24);
        check_val("t6_words", words_written, 3);
        check_val("t6_csum", checksum, 32'h47615555);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr3_wr_control.md
Name: ddr3_wr_control

Overview:
- Downstream consumer of the ADC acquisition stage. Drains the 128-bit header/ADC words that the acquisition block has stored in the DDR3 write FIFO (first-word-fall-through, read side in the DDR3 UI clock domain).
- Writes each word as one BL8 burst through the MIG user (app) interface.
- Keeps the running DDR3 burst address, a per-fill word count and a per-fill 32-bit XOR checksum.
- Drives ddr3_wr_busy back to the acquisition state machine.

Parameters:
ADDR_W, 28, width of app_addr (MIG column/row/bank address)
ADR_STEP, 8, app_addr increment per 128-bit word (one BL8 burst)
DATA_W, 128, FIFO and app_wdf_data width (fixed; other values unsupported)

Ports:
clk  in  1  DDR3 UI clock; the only clock
reset  in  1  asynchronous, active-high
adr_init  in  1  pulse: reset app_addr to 0 and clear adr_wrap (honoured in IDLE only)
fill_done  in  1  pulse (already synchronised to clk): acquisition of the current fill finished
fifo_dout  in  128  FWFT FIFO head word
fifo_empty  in  1  FIFO empty
fifo_rd_en  out  1  pop FIFO head
app_rdy  in  1  MIG command accepted
app_wdf_rdy  in  1  MIG write data accepted
app_en  out  1  command valid
app_cmd  out  3  always 3'b000 (write)
app_addr  out  ADDR_W  burst address
app_wdf_data  out  128  write data
app_wdf_wren  out  1  write data valid
app_wdf_end  out  1  last beat; always equals app_wdf_wren
app_wdf_mask  out  16  always 16'h0000
ddr3_wr_busy  out  1  high whenever state is not IDLE
words_written  out  24  words committed in the current fill
checksum  out  32  XOR of 32-bit lanes of all committed words in the current fill
adr_wrap  out  1  sticky: app_addr wrapped past 2^ADDR_W

Behaviour:
- Reset values: all outputs 0, app_addr = 0, state IDLE, fill_done latch cleared.
- States: IDLE, ISSUE, DONE.
- fill_done pulse sets fd_latch in any state. fd_latch is cleared on entry to DONE.
- IDLE, fifo_empty=1: stay. adr_init=1 sets app_addr=0 and adr_wrap=0.
- IDLE, fifo_empty=1, fd_latch=1: go to DONE (covers a zero-length fill).
- IDLE, fifo_empty=0: pulse fifo_rd_en, capture fifo_dout into the hold register, clear words_written and checksum, go to ISSUE.
- IDLE latency: app_en and app_wdf_wren assert the cycle after the pop.
- ISSUE: app_en is held until app_rdy=1 is sampled with app_en=1; it then drops and cmd_ok is set.
- ISSUE: app_wdf_wren/app_wdf_end are held independently until app_wdf_rdy=1; they then drop and dat_ok is set.
- Command and data may complete in either order or in the same cycle.
- Commit: the cycle in which both are complete (registered flag or the current accept).
- On commit:
  - app_addr += ADR_STEP, modulo 2^ADDR_W; a carry out sets adr_wrap.
  - words_written += 1, saturating at 24'hFFFFFF.
  - checksum ^= d[127:96]^d[95:64]^d[63:32]^d[31:0].
  - cmd_ok and dat_ok are cleared.
- After commit:
  - fifo_empty=0: pop in the same cycle and stay in ISSUE. The new word is presented next cycle, giving 1 word/cycle when both rdy signals stay high.
  - fifo_empty=1 and fd_latch=1: go to DONE.
  - fifo_empty=1 and fd_latch=0: go to a wait sub-condition of ISSUE with app_en=wren=0. Pop when the FIFO goes non-empty; go to DONE when fd_latch sets.
- DONE: one cycle, then IDLE. words_written and checksum hold until the next fill starts.
- adr_init outside IDLE: ignored.
- app_addr, app_wdf_data and the hold register are stable while app_en or app_wdf_wren is high.
- Reset mid-burst: immediate return to reset values. An in-flight MIG command is abandoned.

Decomposition:
- Package ddr3_wr_pkg: state encoding (IDLE, ISSUE, DONE), APP_CMD_WR=3'b000, ADR_STEP, DATA_W.
- One sub-module: ddr3_wr_addr_cntr (address register, step, wrap flag, adr_init).

Test Plan:
- adr_init; 3 FIFO words A,B,C; app_rdy=app_wdf_rdy=1; fill_done after C -> app_addr 0,8,16 on consecutive cycles; words_written=3; checksum=fold(A)^fold(B)^fold(C); busy falls 2 cycles after C commits.
- app_rdy low 4 cycles while app_wdf_rdy=1 -> wren drops after 1 cycle, app_en held 5 cycles, single commit, addr +8 only once.
- fill_done with the FIFO empty in IDLE -> DONE, busy high exactly 2 cycles, words_written=0, checksum=0.
- app_addr preset to 2^28-8; 2 words -> second address 0, adr_wrap=1; adr_init in IDLE clears it.
- Reset asserted while app_en=1 -> all outputs 0 asynchronously; after release, the next word goes to addr 0.
- FIFO goes empty mid-fill for 10 cycles, then 1 more word, then fill_done -> no app_en during the gap; words_written=N+1.
